// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the multi-read-port register bank.
// Holds the clear-engine state encoding, the default geometry, and a helper
// that extracts one read address from the packed read-address bus.
package reg_bank_pkg;

    // Clear engine states: IDLE accepts writes and clear requests; CLEAR sweeps the bank.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

    // Default geometry used by the datapath.
    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NREAD = 2;

    // Upper bounds for the address-unpacking helper.
    // The helper works on a zero-extended copy of the read-address bus.
    localparam int MAX_AW     = 16;
    localparam int MAX_NREAD  = 4;
    localparam int ADDR_BUS_W = MAX_AW * MAX_NREAD;

    // Return read port idx's address from a packed bus holding aw-bit fields.
    // The result is zero-extended to MAX_AW bits.
    // Callers narrow it back to their own address width.
    function automatic logic [MAX_AW-1:0] port_addr(
        input logic [ADDR_BUS_W-1:0] bus,
        input int unsigned           aw,
        input int unsigned           idx
    );
        logic [ADDR_BUS_W-1:0] shifted;
        logic [ADDR_BUS_W-1:0] mask;
        shifted = bus >> (aw * idx);
        mask    = (ADDR_BUS_W'(1) << aw) - ADDR_BUS_W'(1);
        return MAX_AW'(shifted & mask);
    endfunction

endpackage

// File: rtl/reg_bank_clr_ctrl.sv
// Bulk-clear engine for the register bank.
// A request accepted in IDLE starts a sweep on the next cycle. The sweep walks
// addresses 0..DEPTH-1 and writes one entry per cycle, so it lasts exactly
// DEPTH cycles. Requests that arrive during a sweep are ignored.
module reg_bank_clr_ctrl
    import reg_bank_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_req_i,
    output logic          busy_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          clr_we_o
);

    // The sweep ends after this address.
    // The counter never needs to wrap.
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // State and sweep counter registers; reset drops straight back to IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: start on request, then walk the bank once and stop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (clear_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                clr_we_o = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o     = (state_q == CLEAR);
    assign clr_addr_o = cnt_q;

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-read-port register bank.
// It sits between decode (read addresses) and write-back (write port).
// The bank has one synchronous write port and NREAD registered read ports.
// An optional hardwired-zero register 0 ignores writes and always reads 0.
// A sequential bulk-clear engine lets the core wipe the bank without a reset.
//
// Build option REG_BANK_BYPASS_EN:
//   - Defined: a read that hits the address being written at the same edge
//     returns the new data (write-first).
//   - Undefined: that read returns the old contents (read-first).
//   - In either build, writes dropped during a clear sweep are never forwarded.
module reg_bank_mp
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int NREAD    = DEF_NREAD,
    parameter  bit ZERO_REG = 1'b1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [NREAD*AW-1:0]    AR,
    output logic [NREAD*WIDTH-1:0] DR,
    input  logic [AW-1:0]          Awrite,
    input  logic [WIDTH-1:0]       DataIn,
    input  logic                   WReg,
    input  logic                   ClearReq,
    output logic                   Busy,
    output logic                   WDrop
);

    // Storage, read-port registers and drop flag.
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] dr_q  [NREAD];
    logic [WIDTH-1:0] dr_d  [NREAD];
    logic             wdrop_q, wdrop_d;

    // Clear engine interface.
    logic             busy;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;

    // Write qualification and unpacked read addresses.
    logic             wr_zero;
    logic             wr_en;
    logic [AW-1:0]    ar [NREAD];

    reg_bank_clr_ctrl #(
        .DEPTH (DEPTH)
    ) u_clr_ctrl (
        .clk_i       (Clk),
        .rst_ni      (Rst_n),
        .clear_req_i (ClearReq),
        .busy_o      (busy),
        .clr_addr_o  (clr_addr),
        .clr_we_o    (clr_we)
    );

    // Unpacking relies on NREAD <= MAX_NREAD and AW <= MAX_AW.
    // Larger geometries need wider package bounds.
    for (genvar i = 0; i < NREAD; i++) begin : g_ar
        assign ar[i] = AW'(port_addr(ADDR_BUS_W'(AR), AW, i));
        assign DR[i*WIDTH +: WIDTH] = dr_q[i];
    end

    // Writes into register 0 are swallowed silently when it is hardwired.
    // Writes that arrive during a sweep are dropped and flagged.
    assign wr_zero = ZERO_REG && (Awrite == '0);
    assign wr_en   = WReg && !busy && !wr_zero;
    assign wdrop_d = WReg && busy;

    // Storage update: the sweep and the write port never collide.
    // The write port is gated off while the sweep runs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_en) begin
            mem_q[Awrite] <= DataIn;
        end
    end

    // Read-data selection.
    // Sweep writes are not forwarded, so an entry being cleared still reads
    // its old value on that edge.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            dr_d[i] = mem_q[ar[i]];
`ifdef REG_BANK_BYPASS_EN
            if (wr_en && (Awrite == ar[i])) begin
                dr_d[i] = DataIn;
            end
`endif
            if (ZERO_REG && (ar[i] == '0)) begin
                dr_d[i] = '0;
            end
        end
    end

    // Read-port and drop-flag registers: one cycle of read latency.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NREAD; i++) begin
                dr_q[i] <= '0;
            end
            wdrop_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREAD; i++) begin
                dr_q[i] <= dr_d[i];
            end
            wdrop_q <= wdrop_d;
        end
    end

    assign Busy  = busy;
    assign WDrop = wdrop_q;

endmodule

// File: tb/tb_reg_bank_mp.sv
// Testbench for reg_bank_mp.
// A reference model predicts every output cycle into a scoreboard queue, and
// a separate monitor pops and compares one entry per cycle.
// Directed sequences are followed by randomized traffic.
module tb_reg_bank_mp;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;
`ifdef REG_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                   Clk      = 1'b0;
    logic                   Rst_n    = 1'b1;
    logic [NREAD*AW-1:0]    AR       = '0;
    logic [NREAD*WIDTH-1:0] DR;
    logic [AW-1:0]          Awrite   = '0;
    logic [WIDTH-1:0]       DataIn   = '0;
    logic                   WReg     = 1'b0;
    logic                   ClearReq = 1'b0;
    logic                   Busy;
    logic                   WDrop;

    reg_bank_mp #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .NREAD    (NREAD),
        .ZERO_REG (1'b1)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .AR       (AR),
        .DR       (DR),
        .Awrite   (Awrite),
        .DataIn   (DataIn),
        .WReg     (WReg),
        .ClearReq (ClearReq),
        .Busy     (Busy),
        .WDrop    (WDrop)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [NREAD*WIDTH-1:0] dr;
        logic                   busy;
        logic                   wdrop;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state: plain contents array plus sweep progress.
    logic [WIDTH-1:0] ref_mem [DEPTH];
    bit               sweeping;
    int               sweep_pos;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: reads see contents before this edge's update.
    // A write is forwarded only in bypass builds. Register 0 reads zero.
    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
            sweeping  = 1'b0;
            sweep_pos = 0;
            sb.delete();
        end else begin
            exp_t             e;
            bit               wr_ok;
            int               a;
            logic [WIDTH-1:0] val;
            wr_ok = WReg && !sweeping && (int'(Awrite) != 0);
            for (int p = 0; p < NREAD; p++) begin
                a = int'(AR[p*AW +: AW]);
                if (a == 0)                                   val = '0;
                else if (BYP && wr_ok && a == int'(Awrite))   val = DataIn;
                else                                          val = ref_mem[a];
                e.dr[p*WIDTH +: WIDTH] = val;
            end
            e.wdrop = WReg && sweeping;
            if (sweeping) begin
                ref_mem[sweep_pos] = '0;
                sweep_pos++;
                if (sweep_pos == DEPTH) sweeping = 1'b0;
            end else begin
                if (wr_ok) ref_mem[Awrite] = DataIn;
                if (ClearReq) begin
                    sweeping  = 1'b1;
                    sweep_pos = 0;
                end
            end
            e.busy = sweeping;
            sb.push_back(e);
        end
    end

    // Monitor: outputs are registered, so one expectation is due every cycle.
    always @(posedge Clk) begin
        #2;
        if (Rst_n && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            for (int p = 0; p < NREAD; p++)
                chk($sformatf("dr%0d", p), 64'(DR[p*WIDTH +: WIDTH]), 64'(e.dr[p*WIDTH +: WIDTH]));
            chk("busy", 64'(Busy), 64'(e.busy));
            chk("wdrop", 64'(WDrop), 64'(e.wdrop));
        end
    end

    task automatic step(input bit wr, input int wa, input logic [WIDTH-1:0] wd, input bit clr,
                        input int a0, input int a1, output bit busy_seen);
        @(negedge Clk);
        busy_seen = Busy;
        WReg      = wr;
        Awrite    = AW'(wa);
        DataIn    = wd;
        ClearReq  = clr;
        AR        = {AW'(a1), AW'(a0)};
    endtask

    task automatic st(input bit wr, input int wa, input logic [WIDTH-1:0] wd, input bit clr,
                      input int a0, input int a1);
        bit b;
        step(wr, wa, wd, clr, a0, a1, b);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH / 2; i++) st(1'b0, 0, '0, 1'b0, 2 * i, 2 * i + 1);
    endtask

    // Count cycles with Busy high following an accepted request (bounded).
    task automatic count_busy(input bit inject, output int cnt);
        bit b;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            step(inject && (k == 5), 30, 32'hAAAA5555, 1'b0,
                 (inject && k == 6) ? 30 : int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom_range(0, DEPTH - 1)), b);
            if (b) cnt++;
            else if (cnt > 0) break;
        end
    endtask

    initial begin
        int cnt;

        // Reset, then check the outputs while reset is held.
        #1 Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_dr", 64'(DR), 64'(0));
        chk("rst_busy", 64'(Busy), 64'(0));
        chk("rst_wdrop", 64'(WDrop), 64'(0));
        @(negedge Clk) Rst_n = 1'b1;
        st(1'b0, 0, '0, 1'b0, 0, 1);

        // Basic write then read on both ports.
        st(1'b1, 9, 32'd358, 1'b0, 0, 0);
        st(1'b1, 15, 32'd77, 1'b0, 0, 0);
        st(1'b0, 0, '0, 1'b0, 9, 15);

        // Hardwired zero register.
        st(1'b1, 0, 32'hDEADBEEF, 1'b0, 0, 0);
        st(1'b0, 0, '0, 1'b0, 0, 0);

        // Same-edge write/read hazard.
        st(1'b1, 4, 32'd5, 1'b0, 0, 0);
        st(1'b1, 4, 32'd99, 1'b0, 4, 4);
        st(1'b0, 0, '0, 1'b0, 4, 4);

        // Fill and sweep.
        // A write is injected mid-sweep and read back on the next cycle.
        for (int i = 1; i < DEPTH; i++) st(1'b1, i, 32'(i), 1'b0, i, 0);
        st(1'b0, 0, '0, 1'b1, 0, 0);
        count_busy(1'b1, cnt);
        chk("busy_len", 64'(cnt), 64'(DEPTH));
        read_all();

        // Reset in the middle of a sweep.
        for (int i = 1; i < DEPTH; i++) st(1'b1, i, 32'(i * 3 + 1), 1'b0, 0, 0);
        st(1'b0, 0, '0, 1'b1, 0, 0);
        repeat (10) st(1'b0, 0, '0, 1'b0, 0, 0);
        @(posedge Clk);
        #4 Rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(Busy), 64'(0));
        chk("midrst_dr", 64'(DR), 64'(0));
        @(negedge Clk) Rst_n = 1'b1;
        read_all();
        st(1'b0, 0, '0, 1'b1, 0, 0);
        count_busy(1'b0, cnt);
        chk("busy_len2", 64'(cnt), 64'(DEPTH));

        // Randomized traffic.
        repeat (1500) begin
            st(1'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)), $urandom,
               ($urandom_range(0, 49) == 0),
               int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)));
        end

        repeat (3) st(1'b0, 0, '0, 1'b0, 0, 0);
        @(posedge Clk);
        #4;
        chk("sb_drain", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_bank_mp.md
Name: reg_bank_mp

Overview:
Parametrised multi-read-port register bank, the next generation of reg_bank for the datapath.
- Write: one synchronous write port.
- Read: NREAD synchronous read ports, one cycle of latency.
- Register 0 is hardwired to zero (optional).
- Sequential bulk-clear engine (FSM plus address counter) so the core can wipe the bank without a reset.
- Sits between decode (read addresses) and write-back (write address/data).

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 32, number of registers; power of two, >=2
AW, $clog2(DEPTH), address width (derived localparam, not overridable)
NREAD, 2, number of read ports, 1..4
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes

Ports:
Clk  input  1  clock; all state updates on rising edge
Rst_n  input  1  asynchronous, active-low reset
AR  input  NREAD*AW  read addresses, packed; port i at [i*AW +: AW]
DR  output  NREAD*WIDTH  read data, packed; port i at [i*WIDTH +: WIDTH]
Awrite  input  AW  write address
DataIn  input  WIDTH  write data
WReg  input  1  write enable
ClearReq  input  1  start bulk clear; sampled while idle
Busy  output  1  clear sweep in progress
WDrop  output  1  one-cycle pulse: a write was discarded

Behaviour:
Reset (Rst_n low, asynchronous):
- All registers = 0; DR = 0; Busy = 0; WDrop = 0.
- FSM = IDLE; clear counter = 0.
- Takes effect immediately and holds until Rst_n rises.
Write (IDLE):
- WReg=1 at the rising edge writes DataIn to Awrite.
- If ZERO_REG=1 and Awrite=0: no write, no WDrop.
Read:
- DR port i registers mem[AR_i] at every rising edge, so data appears one cycle after the address.
- Address 0 with ZERO_REG=1 returns 0.
- With several ports on the same address, every port returns the same value.
Same-cycle write and read of one address:
- See Optional Feature.
FSM states IDLE, CLEAR:
- IDLE -> CLEAR when ClearReq=1. Busy rises the next cycle; counter = 0.
- CLEAR: each cycle writes 0 to mem[counter], then counter+1.
- CLEAR -> IDLE after writing DEPTH-1. Busy falls the following cycle. The sweep takes exactly DEPTH cycles.
- ClearReq during CLEAR is ignored; the sweep does not restart.
- In the cycle ClearReq is accepted, a concurrent WReg write still completes.
- In CLEAR, WReg=1 is discarded and WDrop=1 for one cycle.
- Reads continue in CLEAR and return current contents: zeros for swept addresses, old data otherwise.
- Reset mid-sweep aborts to IDLE with every register at 0.
Width rules:
- No arithmetic on data.
- Counter is AW bits; it does not wrap, because the FSM exits at DEPTH-1.

Optional Feature:
Macro REG_BANK_BYPASS_EN.
- Defined: when WReg=1 in IDLE and Awrite==AR_i at the same edge, DR_i captures DataIn (write-first). Exception: address 0 with ZERO_REG=1 still returns 0.
- Undefined: DR_i captures the old mem contents (read-first). The new value is visible from the next read.
- WDrop-discarded writes are never forwarded, in either build.

Decomposition:
Package reg_bank_pkg holds:
- state enum (IDLE, CLEAR);
- default WIDTH/DEPTH/NREAD constants;
- a function to unpack port i of a packed address bus.
Sub-module reg_bank_clr_ctrl holds the FSM and counter. It outputs Busy, clear address and clear-write-enable. The top holds the storage array, read ports and bypass logic.

Test Plan:
1. Reset then read: Rst_n=0 for 2 cycles, release, AR={1,0} -> DR={0,0} after 1 cycle; Busy=0, WDrop=0.
2. Write/read: write 358 to reg 9, then 77 to reg 15; AR0=9, AR1=15 -> next cycle DR0=358, DR1=77.
3. Zero register: WReg=1, Awrite=0, DataIn=0xDEADBEEF; read AR0=0 -> 0; WDrop stays 0.
4. Same-cycle hazard: reg 4 holds 5; write 99 to reg 4 with AR0=4 at the same edge -> DR0=99 with REG_BANK_BYPASS_EN, 5 without; next read = 99 in both.
5. Bulk clear: fill regs 1..31 with their index; pulse ClearReq.
   - Busy high for exactly 32 cycles.
   - Write during the sweep -> WDrop pulse, data not stored.
   - After Busy falls, all 32 registers read 0.
6. Reset mid-sweep: assert Rst_n=0 at sweep cycle 10 -> Busy=0 immediately; all registers 0; a ClearReq after release starts a fresh 32-cycle sweep.
